// File: rtl/thread_pc_bank.sv
// Per-thread program counter bank for a 4-thread barrel core: issues the selected thread's PC
// toward fetch each cycle and applies redirects, halts and restart. Optional macro: THREAD_PC_ISSUE_CNT_EN.
module thread_pc_bank #(
   parameter int PC_W          = 9,
   parameter int RESET_PC      = 0,
   parameter int THREAD_STRIDE = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable,
   input  logic [1:0]      thread_in,
   input  logic            branch_valid,
   input  logic [1:0]      branch_thread,
   input  logic [PC_W-1:0] branch_target,
   input  logic            halt_valid,
   input  logic [1:0]      halt_thread,
   input  logic            start,
`ifdef THREAD_PC_ISSUE_CNT_EN
   input  logic [1:0]      cnt_sel,
   output logic [15:0]     issue_cnt,
`endif
   output logic [PC_W-1:0] pc_out,
   output logic [1:0]      pc_thread,
   output logic            pc_valid,
   output logic            all_halted
);

   typedef enum logic {RUN = 1'b0, HALTED = 1'b1} thr_state_t;

   thr_state_t      state [4];
   logic [PC_W-1:0] pc    [4];
   logic            issue;
   logic [3:0]      halted_nxt;

   function automatic logic [PC_W-1:0] rst_pc(input int i);
      rst_pc = PC_W'(RESET_PC + i * THREAD_STRIDE);
   endfunction

   // A halt requested on the issuing thread does not suppress this cycle's issue.
   always_comb begin
      issue = enable && (state[thread_in] == RUN) && !start;
      halted_nxt = '0;
      for (int i = 0; i < 4; i++)
         halted_nxt[i] = (state[i] == HALTED) || (halt_valid && (halt_thread == 2'(i)));
   end

`ifdef THREAD_PC_ISSUE_CNT_EN
   logic [15:0] cnt [4];
   assign issue_cnt = cnt[cnt_sel];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            pc[i]    <= rst_pc(i);
            state[i] <= RUN;
`ifdef THREAD_PC_ISSUE_CNT_EN
            cnt[i]   <= '0;
`endif
         end
         pc_out     <= '0;
         pc_thread  <= '0;
         pc_valid   <= 1'b0;
         all_halted <= 1'b0;
      end else begin
         pc_out    <= pc[thread_in];
         pc_thread <= thread_in;
         pc_valid  <= issue;
         if (start) begin
            for (int i = 0; i < 4; i++) begin
               pc[i]    <= rst_pc(i);
               state[i] <= RUN;
`ifdef THREAD_PC_ISSUE_CNT_EN
               cnt[i]   <= '0;
`endif
            end
            all_halted <= 1'b0;
         end else begin
            // A redirect overrides the issue increment on the same thread.
            for (int i = 0; i < 4; i++) begin
               if (branch_valid && (branch_thread == 2'(i)))
                  pc[i] <= branch_target;
               else if (issue && (thread_in == 2'(i)))
                  pc[i] <= pc[i] + PC_W'(1);
               state[i] <= halted_nxt[i] ? HALTED : RUN;
`ifdef THREAD_PC_ISSUE_CNT_EN
               if (issue && (thread_in == 2'(i)))
                  cnt[i] <= cnt[i] + 16'd1;
`endif
            end
            all_halted <= &halted_nxt;
         end
      end
   end

endmodule

// File: tb/tb_thread_pc_bank.sv
// Bench for thread_pc_bank: directed vector table, async reset sequence, then randomized traffic
// against an array-based model of the per-thread PC/halt rules.
module tb_thread_pc_bank;

   localparam int PC_W = 9;
   localparam int STRIDE = 64;
   localparam int PC_MOD = 1 << PC_W;

   logic            clk = 1'b0;
   logic            rst, enable, branch_valid, halt_valid, start;
   logic [1:0]      thread_in, branch_thread, halt_thread;
   logic [PC_W-1:0] branch_target;
   logic [PC_W-1:0] pc_out;
   logic [1:0]      pc_thread;
   logic            pc_valid, all_halted;
`ifdef THREAD_PC_ISSUE_CNT_EN
   logic [1:0]      cnt_sel;
   logic [15:0]     issue_cnt;
`endif

   always #5 clk = ~clk;

   thread_pc_bank #(.PC_W(PC_W), .RESET_PC(0), .THREAD_STRIDE(STRIDE)) dut (
      .clk(clk), .rst(rst), .enable(enable), .thread_in(thread_in),
      .branch_valid(branch_valid), .branch_thread(branch_thread), .branch_target(branch_target),
      .halt_valid(halt_valid), .halt_thread(halt_thread), .start(start),
`ifdef THREAD_PC_ISSUE_CNT_EN
      .cnt_sel(cnt_sel), .issue_cnt(issue_cnt),
`endif
      .pc_out(pc_out), .pc_thread(pc_thread), .pc_valid(pc_valid), .all_halted(all_halted)
   );

   typedef struct {
      logic en; logic [1:0] t;
      logic bv; logic [1:0] bt; logic [PC_W-1:0] tgt;
      logic hv; logic [1:0] ht; logic st;
      int e_pc; int e_t; int e_v; int e_ah;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model state
   int m_pc [4];
   bit m_halt [4];
   int m_cnt [4];
   int x_pc, x_t, x_v, x_ah;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_pc[i] = (i * STRIDE) % PC_MOD;
         m_halt[i] = 1'b0;
         m_cnt[i] = 0;
      end
   endtask

   task automatic model_step(input vec_t v);
      x_pc = m_pc[v.t];
      x_t = v.t;
      if (v.st) begin
         x_v = 0;
         model_reset();
      end else begin
         x_v = (v.en && !m_halt[v.t]) ? 1 : 0;
         if (x_v == 1) begin
            m_pc[v.t] = (m_pc[v.t] + 1) % PC_MOD;
            m_cnt[v.t] = (m_cnt[v.t] + 1) % 65536;
         end
         if (v.bv) m_pc[v.bt] = v.tgt;
         if (v.hv) m_halt[v.ht] = 1'b1;
      end
      x_ah = (m_halt[0] && m_halt[1] && m_halt[2] && m_halt[3]) ? 1 : 0;
   endtask

   // Drives one cycle, advances the model, samples 1 time unit after the edge.
   task automatic run_cycle(input vec_t v);
      enable = v.en; thread_in = v.t;
      branch_valid = v.bv; branch_thread = v.bt; branch_target = v.tgt;
      halt_valid = v.hv; halt_thread = v.ht; start = v.st;
      model_step(v);
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic en, input int t, input logic bv, input int bt, input int tgt,
                               input logic hv, input int ht, input logic st,
                               input int e_pc, input int e_t, input int e_v, input int e_ah);
      vec_t v;
      v.en = en; v.t = 2'(t); v.bv = bv; v.bt = 2'(bt); v.tgt = PC_W'(tgt);
      v.hv = hv; v.ht = 2'(ht); v.st = st;
      v.e_pc = e_pc; v.e_t = e_t; v.e_v = e_v; v.e_ah = e_ah;
      return v;
   endfunction

   function automatic vec_t idle(input logic en, input int t);
      return mk(en, t, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   task automatic check_outputs(input string tag, input int e_pc, input int e_t, input int e_v, input int e_ah);
      chk({tag, ".pc_out"}, int'(pc_out), e_pc);
      chk({tag, ".pc_thread"}, int'(pc_thread), e_t);
      chk({tag, ".pc_valid"}, int'(pc_valid), e_v);
      chk({tag, ".all_halted"}, int'(all_halted), e_ah);
   endtask

   initial begin
      vec_t v;
      rst = 1'b1; enable = 0; thread_in = 0; branch_valid = 0; branch_thread = 0;
      branch_target = 0; halt_valid = 0; halt_thread = 0; start = 0;
`ifdef THREAD_PC_ISSUE_CNT_EN
      cnt_sel = 0;
`endif
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs("reset", 0, 0, 0, 0);
      rst = 1'b0;

      //          en t  bv bt tgt  hv ht st   pc  t  v ah
      tbl.push_back(mk(1, 0, 0, 0, 0,   0, 0, 0,   0, 0, 1, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0,   0, 0, 0,  64, 1, 1, 0));
      tbl.push_back(mk(1, 2, 0, 0, 0,   0, 0, 0, 128, 2, 1, 0));
      tbl.push_back(mk(1, 3, 0, 0, 0,   0, 0, 0, 192, 3, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0,   0, 0, 0,   1, 0, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0,   0, 0, 0,  65, 1, 0, 0));
      tbl.push_back(mk(0, 2, 0, 0, 0,   0, 0, 0, 129, 2, 0, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0,   0, 0, 0, 193, 3, 0, 0));
      tbl.push_back(mk(1, 1, 1, 1, 300, 0, 0, 0,  65, 1, 1, 0));
      tbl.push_back(mk(1, 2, 0, 0, 0,   0, 0, 0, 129, 2, 1, 0));
      tbl.push_back(mk(1, 3, 0, 0, 0,   0, 0, 0, 193, 3, 1, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0,   0, 0, 0, 300, 1, 1, 0));
      tbl.push_back(mk(1, 2, 0, 0, 0,   1, 2, 0, 130, 2, 1, 0));
      tbl.push_back(mk(1, 2, 0, 0, 0,   0, 0, 0, 131, 2, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0,   1, 0, 0,   2, 0, 1, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0,   1, 1, 0, 301, 1, 1, 0));
      tbl.push_back(mk(1, 3, 0, 0, 0,   1, 3, 0, 194, 3, 1, 1));
      tbl.push_back(mk(1, 2, 0, 0, 0,   0, 0, 0, 131, 2, 0, 1));
      tbl.push_back(mk(1, 0, 1, 0, 77,  1, 1, 1,   3, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0,   0, 0, 0,   0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 1, 3, 511, 0, 0, 0,   1, 0, 0, 0));
      tbl.push_back(mk(1, 3, 0, 0, 0,   0, 0, 0, 511, 3, 1, 0));
      tbl.push_back(mk(1, 3, 0, 0, 0,   0, 0, 0,   0, 3, 1, 0));
      tbl.push_back(mk(1, 2, 1, 2, 10,  1, 2, 0, 128, 2, 1, 0));
      tbl.push_back(mk(1, 2, 0, 0, 0,   0, 0, 0,  10, 2, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0,   0, 0, 0,  64, 1, 1, 0));

      foreach (tbl[k]) begin
         run_cycle(tbl[k]);
         check_outputs($sformatf("vec%0d", k), tbl[k].e_pc, tbl[k].e_t, tbl[k].e_v, tbl[k].e_ah);
      end

      // Asynchronous reset mid-rotation, released at a falling edge.
      rst = 1'b1;
      #1;
      check_outputs("async_rst", 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      run_cycle(idle(1, 1));
      check_outputs("post_rst", 64, 1, 1, 0);

`ifdef THREAD_PC_ISSUE_CNT_EN
      run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      for (int k = 0; k < 8; k++) run_cycle(idle(1, k % 4));
      for (int s = 0; s < 4; s++) begin
         cnt_sel = 2'(s);
         #1;
         chk($sformatf("cnt_rot%0d", s), int'(issue_cnt), 2);
      end
      run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      for (int s = 0; s < 4; s++) begin
         cnt_sel = 2'(s);
         #1;
         chk($sformatf("cnt_clr%0d", s), int'(issue_cnt), 0);
      end
`endif

      // Randomized traffic against the model.
      for (int k = 0; k < 400; k++) begin
         v.en  = ($urandom_range(0, 7) != 0);
         v.t   = 2'($urandom_range(0, 3));
         v.bv  = ($urandom_range(0, 3) == 0);
         v.bt  = 2'($urandom_range(0, 3));
         v.tgt = PC_W'($urandom_range(0, PC_MOD - 1));
         v.hv  = ($urandom_range(0, 9) == 0);
         v.ht  = 2'($urandom_range(0, 3));
         v.st  = ($urandom_range(0, 24) == 0);
`ifdef THREAD_PC_ISSUE_CNT_EN
         cnt_sel = 2'($urandom_range(0, 3));
`endif
         run_cycle(v);
         check_outputs($sformatf("rnd%0d", k), x_pc, x_t, x_v, x_ah);
`ifdef THREAD_PC_ISSUE_CNT_EN
         chk($sformatf("rnd%0d.issue_cnt", k), int'(issue_cnt), m_cnt[cnt_sel]);
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/thread_pc_bank.md
Name: thread_pc_bank

Overview:
- Consumer end of the 2-bit round-robin thread ID from the thread controller, for the 4-thread fine-grained multithreaded core.
- Holds one program counter and one run/halt state per thread.
- Each cycle, registers the PC of the thread named on thread_in toward instruction fetch, then advances that thread's PC.
- Accepts thread-tagged branch redirects and halt requests from the back end of the pipeline.

Parameters:
- PC_W, 9, PC width in bits; instruction-word address, wraps mod 2^PC_W.
- RESET_PC, 0, base PC for thread 0.
- THREAD_STRIDE, 64, reset PC offset between threads; thread i resets to RESET_PC + i*THREAD_STRIDE, truncated to PC_W bits.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst, in, 1, asynchronous active-high reset.
- enable, in, 1, issue enable; 0 freezes issue and PC increment.
- thread_in, in, 2, thread selected this cycle (from thread controller).
- branch_valid, in, 1, redirect request.
- branch_thread, in, 2, thread to redirect.
- branch_target, in, PC_W, new PC.
- halt_valid, in, 1, halt request.
- halt_thread, in, 2, thread to halt.
- start, in, 1, pulse: all threads to RUN, PCs to reset values.
- pc_out, out, PC_W, fetch PC.
- pc_thread, out, 2, thread tag of pc_out.
- pc_valid, out, 1, pc_out is a valid issue.
- all_halted, out, 1, all 4 threads HALTED.

Behaviour:
- Reset (async, rst=1):
  - pc[i] = RESET_PC + i*THREAD_STRIDE; all threads RUN.
  - pc_out=0, pc_thread=0, pc_valid=0, all_halted=0.
- Per-thread state machine:
  - States: RUN, HALTED.
  - RUN -> HALTED when halt_valid and halt_thread==i.
  - HALTED -> RUN only on start.
- Issue (registered, latency 1 cycle):
  - If enable=1 and thread t=thread_in is RUN: next cycle pc_out=pc[t] (pre-increment value), pc_thread=t, pc_valid=1.
  - Same edge: pc[t] <= pc[t]+1, wrapping 2^PC_W-1 -> 0.
  - If enable=0 or t is HALTED: pc_valid=0, no increment. pc_out/pc_thread still update to pc[t]/t.
- Branch: branch_valid writes pc[branch_thread] <= branch_target. Applied regardless of halt state or enable.
- Priorities, same thread, same edge:
  - branch beats increment; the issued pc_out still shows the old pc[t].
  - branch + halt both apply: PC = target, state = HALTED.
  - halt on the issuing thread still issues that cycle (pc_valid=1); suppression starts next cycle.
- start:
  - Highest priority: all PCs to reset values, all RUN.
  - Same-edge branch/halt/increment ignored.
  - pc_valid=0 that cycle.
- Different threads in branch/halt/issue on the same edge are independent and all apply.
- all_halted: registered; equals AND of HALTED states after the edge.
- Mid-operation rst: immediate return to reset values; no partial updates.

Optional Feature:
- Macro: THREAD_PC_ISSUE_CNT_EN.
- Defined:
  - Adds input cnt_sel[1:0] and output issue_cnt[15:0].
  - One 16-bit counter per thread; increments on every cycle where that thread gets pc_valid=1; wraps at 0xFFFF.
  - Counters clear on rst and start.
  - issue_cnt = combinational read of counter[cnt_sel].
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then enable=1 with thread_in cycling 0,1,2,3,0:
  - pc_out sequence 0,64,128,192,1.
  - pc_thread 0,1,2,3,0; pc_valid=1 throughout.
- enable=0 for 3 cycles mid-rotation, then enable=1:
  - pc_valid=0 while disabled; PCs unchanged.
  - Resume continues from the next unissued values.
- Thread 1 issuing at pc 65 with the same edge branch_valid, branch_thread=1, branch_target=300:
  - That issue shows pc_out=65.
  - Next thread-1 issue shows pc_out=300.
- halt_valid for thread 2, then halt 0,1,3:
  - Thread 2 issues get pc_valid=0 from the following cycle; its PC is frozen.
  - all_halted=1 after the last halt.
  - start pulse -> all RUN; thread 0 issues pc_out=0.
- PC wrap: branch thread 3 to 511, then issue thread 3 twice -> pc_out 511, then 0.
- Assert rst mid-rotation -> outputs 0 immediately. Release -> thread 1 issues pc_out=64.
- With THREAD_PC_ISSUE_CNT_EN: 8 cycles of rotation -> issue_cnt=2 for each cnt_sel; start clears all counters to 0.
